// File: rtl/rv32_inst_encoder.sv
// -----------------------------------------------------------------------------
// rv32_inst_encoder
//
// Purpose:
//   Inverse of the core's instruction decoder. Takes decoded fields
//   (instruction ID, rd, rs1, rs2, sign-extended immediate) and produces the
//   32-bit RV32I instruction word. Each emitted word carries an
//   auto-incrementing word address, so a bench or boot loader can stream a
//   program straight into instruction memory.
//
//   Supported subset: ADDI, ADD, LUI, BNE, JAL, LW, SW.
//
// Structure:
//   The encoder is combinational from the request fields. The encoded word is
//   captured, together with its address tag, directly into a 2-entry output
//   FIFO. That FIFO write is the registered encode stage: a request accepted
//   on one edge is visible at the FIFO head right after that edge.
//
// Ports:
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous active-low reset
//   hold       in   1       stall request acceptance (FIFO keeps draining)
//   in_valid   in   1       request valid
//   in_ready   out  1       request accepted when in_valid && in_ready
//   in_instID  in   `InstIDDepth  instruction ID (`ID_ADDI ... `ID_SW)
//   in_rd      in   5       destination register
//   in_rs1     in   5       source register 1
//   in_rs2     in   5       source register 2
//   in_imm     in   32      sign-extended immediate (byte offset for BNE/JAL,
//                           full upper value for LUI)
//   out_valid  out  1       FIFO head valid
//   out_ready  in   1       consumer pops the head when out_valid && out_ready
//   out_inst   out  32      encoded instruction word at the FIFO head
//   out_addr   out  ADDR_W  word address of out_inst
//   error      out  1       sticky illegal-request flag, cleared only by reset
//
// Parameters:
//   ADDR_W     width of the word-address counter (wraps silently)
//   BASE_ADDR  address given to the first word emitted after reset
//
// Build option:
//   ENCODER_RANGE_CHECK_EN  when defined, immediates that do not fit their
//   instruction field are flagged as illegal instead of being truncated.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising edge where valid && ready are both high.
//   valid never depends on ready. A producer holding valid keeps its payload
//   stable until the transfer; the output payload is stable while
//   out_valid && !out_ready.
// -----------------------------------------------------------------------------

// Instruction IDs and encoding constants shared with the core's decoder.
// Guarded so that a project-wide defines file takes precedence.
`ifndef InstIDDepth
`define InstIDDepth 4
`endif
`ifndef ID_ADDI
`define ID_ADDI 4'd0
`endif
`ifndef ID_ADD
`define ID_ADD 4'd1
`endif
`ifndef ID_LUI
`define ID_LUI 4'd2
`endif
`ifndef ID_BNE
`define ID_BNE 4'd3
`endif
`ifndef ID_JAL
`define ID_JAL 4'd4
`endif
`ifndef ID_LW
`define ID_LW 4'd5
`endif
`ifndef ID_SW
`define ID_SW 4'd6
`endif
`ifndef OPC_OP_IMM
`define OPC_OP_IMM 7'b0010011
`endif
`ifndef OPC_OP
`define OPC_OP 7'b0110011
`endif
`ifndef OPC_LUI
`define OPC_LUI 7'b0110111
`endif
`ifndef OPC_BRANCH
`define OPC_BRANCH 7'b1100011
`endif
`ifndef OPC_JAL
`define OPC_JAL 7'b1101111
`endif
`ifndef OPC_LOAD
`define OPC_LOAD 7'b0000011
`endif
`ifndef OPC_STORE
`define OPC_STORE 7'b0100011
`endif
`ifndef F3_ADDI
`define F3_ADDI 3'b000
`endif
`ifndef F3_ADD
`define F3_ADD 3'b000
`endif
`ifndef F3_BNE
`define F3_BNE 3'b001
`endif
`ifndef F3_LW
`define F3_LW 3'b010
`endif
`ifndef F3_SW
`define F3_SW 3'b010
`endif

module rv32_inst_encoder #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    hold,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [`InstIDDepth-1:0] in_instID,
    input  logic [4:0]              in_rd,
    input  logic [4:0]              in_rs1,
    input  logic [4:0]              in_rs2,
    input  logic [31:0]             in_imm,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_inst,
    output logic [ADDR_W-1:0]       out_addr,
    output logic                    error
);

    localparam logic [ADDR_W-1:0] LP_BASE = ADDR_W'(BASE_ADDR);
    localparam logic [1:0]        LP_DEPTH = 2'd2;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]        r_count;
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [31:0]       r_mem_inst [2];
    logic [ADDR_W-1:0] r_mem_addr [2];
    logic [ADDR_W-1:0] r_addr;
    logic              r_error;

    // -------------------------------------------------------------------------
    // Combinational signals
    // -------------------------------------------------------------------------
    logic        w_accept;
    logic        w_push;
    logic        w_pop;
    logic        w_known_id;
    logic        w_range_ok;
    logic        w_legal;
    logic [31:0] w_inst;

    // -------------------------------------------------------------------------
    // Request side
    // -------------------------------------------------------------------------
    // Gating with rst_n keeps in_ready low for the whole reset interval even
    // though the FIFO count already reads zero.
    assign in_ready = rst_n && !hold && (r_count < LP_DEPTH);
    assign w_accept = in_valid && in_ready;

    // An illegal request still completes its handshake but never reaches the
    // FIFO and does not consume an address.
    assign w_legal  = w_known_id && w_range_ok;
    assign w_push   = w_accept && w_legal;

    // -------------------------------------------------------------------------
    // Encoder
    // -------------------------------------------------------------------------
    always_comb begin
        w_inst     = 32'd0;
        w_known_id = 1'b1;
        case (in_instID)
            `ID_ADDI: w_inst = {in_imm[11:0], in_rs1, `F3_ADDI, in_rd, `OPC_OP_IMM};
            `ID_ADD:  w_inst = {7'b0000000, in_rs2, in_rs1, `F3_ADD, in_rd, `OPC_OP};
            `ID_LUI:  w_inst = {in_imm[31:12], in_rd, `OPC_LUI};
            // B-type scatters the even byte offset; bit 0 is implied zero.
            `ID_BNE:  w_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, `F3_BNE,
                                in_imm[4:1], in_imm[11], `OPC_BRANCH};
            // J-type likewise drops bit 0 of the offset.
            `ID_JAL:  w_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                                in_rd, `OPC_JAL};
            `ID_LW:   w_inst = {in_imm[11:0], in_rs1, `F3_LW, in_rd, `OPC_LOAD};
            `ID_SW:   w_inst = {in_imm[11:5], in_rs2, in_rs1, `F3_SW, in_imm[4:0],
                                `OPC_STORE};
            default:  w_known_id = 1'b0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Immediate range check
    // -------------------------------------------------------------------------
`ifdef ENCODER_RANGE_CHECK_EN
    // A value fits an N-bit signed field when every bit above the field's
    // sign bit equals that sign bit, i.e. the slice is all zeros or all ones.
    logic w_fit12;
    logic w_fit13;
    logic w_fit21;

    assign w_fit12 = (&in_imm[31:11]) || !(|in_imm[31:11]);
    assign w_fit13 = (&in_imm[31:12]) || !(|in_imm[31:12]);
    assign w_fit21 = (&in_imm[31:20]) || !(|in_imm[31:20]);

    always_comb begin
        w_range_ok = 1'b1;
        case (in_instID)
            `ID_ADDI, `ID_LW, `ID_SW: w_range_ok = w_fit12;
            `ID_BNE:                  w_range_ok = w_fit13 && !in_imm[0];
            `ID_JAL:                  w_range_ok = w_fit21 && !in_imm[0];
            `ID_LUI:                  w_range_ok = (in_imm[11:0] == 12'd0);
            default:                  w_range_ok = 1'b1;
        endcase
    end
`else
    // Immediates are truncated to their field width by the encoder.
    assign w_range_ok = 1'b1;
`endif

    // -------------------------------------------------------------------------
    // Output FIFO (2 entries) and address counter
    // -------------------------------------------------------------------------
    assign w_pop     = (r_count != 2'd0) && out_ready;
    assign out_valid = (r_count != 2'd0);
    assign out_inst  = r_mem_inst[r_rd_ptr];
    assign out_addr  = r_mem_addr[r_rd_ptr];
    assign error     = r_error;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_inst[0] <= 32'd0;
            r_mem_inst[1] <= 32'd0;
            r_mem_addr[0] <= '0;
            r_mem_addr[1] <= '0;
            r_wr_ptr      <= 1'b0;
            r_addr        <= LP_BASE;
        end else if (w_push) begin
            r_mem_inst[r_wr_ptr] <= w_inst;
            r_mem_addr[r_wr_ptr] <= r_addr;
            r_wr_ptr             <= ~r_wr_ptr;
            // Wrap from all-ones back to zero is intentional.
            r_addr               <= r_addr + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= 1'b0;
        end else if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
        end
    end

    // Simultaneous push and pop leaves the occupancy unchanged; the pointer
    // updates above move the new word to the head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_error <= 1'b0;
        end else if (w_accept && !w_legal) begin
            r_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rv32_inst_encoder.sv
// -----------------------------------------------------------------------------
// tb_rv32_inst_encoder
//
// Two encoder instances share every input: the main one (ADDR_W=10,
// BASE_ADDR=100) and a narrow one (ADDR_W=2, BASE_ADDR=0) whose address
// counter wraps quickly. A negedge monitor keeps a reference model of both
// FIFOs as expected queues, pushed when a request is accepted and popped when
// the consumer takes the head.
// -----------------------------------------------------------------------------

`ifndef InstIDDepth
`define InstIDDepth 4
`endif
`ifndef ID_ADDI
`define ID_ADDI 4'd0
`endif
`ifndef ID_ADD
`define ID_ADD 4'd1
`endif
`ifndef ID_LUI
`define ID_LUI 4'd2
`endif
`ifndef ID_BNE
`define ID_BNE 4'd3
`endif
`ifndef ID_JAL
`define ID_JAL 4'd4
`endif
`ifndef ID_LW
`define ID_LW 4'd5
`endif
`ifndef ID_SW
`define ID_SW 4'd6
`endif

module tb_rv32_inst_encoder;

    localparam int ADDR_W  = 10;
    localparam int BASE    = 100;
    localparam int ADDR_WB = 2;

    // -------------------------------------------------------------------------
    // Clock / reset
    // -------------------------------------------------------------------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // -------------------------------------------------------------------------
    // DUT signals
    // -------------------------------------------------------------------------
    logic                    hold      = 1'b0;
    logic                    in_valid  = 1'b0;
    logic                    out_ready = 1'b0;
    logic [`InstIDDepth-1:0] in_instID = '0;
    logic [4:0]              in_rd     = '0;
    logic [4:0]              in_rs1    = '0;
    logic [4:0]              in_rs2    = '0;
    logic [31:0]             in_imm    = '0;

    logic                    in_ready,  in_ready_b;
    logic                    out_valid, out_valid_b;
    logic [31:0]             out_inst,  out_inst_b;
    logic [ADDR_W-1:0]       out_addr;
    logic [ADDR_WB-1:0]      out_addr_b;
    logic                    error,     error_b;

    rv32_inst_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) u_dut (
        .clk(clk), .rst_n(rst_n), .hold(hold),
        .in_valid(in_valid), .in_ready(in_ready), .in_instID(in_instID),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_addr(out_addr), .error(error)
    );

    rv32_inst_encoder #(.ADDR_W(ADDR_WB), .BASE_ADDR(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .hold(hold),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_instID(in_instID),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_inst(out_inst_b), .out_addr(out_addr_b), .error(error_b)
    );

    // -------------------------------------------------------------------------
    // Scoreboard state
    // -------------------------------------------------------------------------
    logic [ADDR_W+31:0]  exp_q[$];
    logic [ADDR_WB+31:0] exp_b_q[$];
    logic [ADDR_W-1:0]   m_addr   = ADDR_W'(BASE);
    logic [ADDR_WB-1:0]  m_addr_b = '0;
    logic                m_error  = 1'b0;
    int                  acc_cnt  = 0;
    logic                drv_has_known = 1'b0;
    logic [31:0]         drv_known     = '0;
    logic                rand_mode     = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    function automatic logic model_legal(input logic [`InstIDDepth-1:0] id, input logic [31:0] imm);
        logic known;
        logic ok;
        known = (id == `ID_ADDI) || (id == `ID_ADD) || (id == `ID_LUI) || (id == `ID_BNE) ||
                (id == `ID_JAL)  || (id == `ID_LW)  || (id == `ID_SW);
        ok = 1'b1;
`ifdef ENCODER_RANGE_CHECK_EN
        if (id == `ID_ADDI || id == `ID_LW || id == `ID_SW)
            ok = ($signed(imm) >= -2048) && ($signed(imm) <= 2047);
        else if (id == `ID_BNE)
            ok = ($signed(imm) >= -4096) && ($signed(imm) <= 4095) && (imm[0] == 1'b0);
        else if (id == `ID_JAL)
            ok = ($signed(imm) >= -1048576) && ($signed(imm) <= 1048575) && (imm[0] == 1'b0);
        else if (id == `ID_LUI)
            ok = (imm[11:0] == 12'h000);
`endif
        return known && ok;
    endfunction

    function automatic logic [31:0] model_enc(input logic [`InstIDDepth-1:0] id,
                                              input logic [4:0] rd, input logic [4:0] rs1,
                                              input logic [4:0] rs2, input logic [31:0] imm);
        logic [31:0] w;
        w = 32'h0;
        if (id == `ID_ADDI || id == `ID_LW) begin
            w[31:20] = imm[11:0];
            w[19:15] = rs1;
            w[14:12] = (id == `ID_LW) ? 3'd2 : 3'd0;
            w[11:7]  = rd;
            w[6:0]   = (id == `ID_LW) ? 7'h03 : 7'h13;
        end else if (id == `ID_ADD) begin
            w[24:20] = rs2;
            w[19:15] = rs1;
            w[11:7]  = rd;
            w[6:0]   = 7'h33;
        end else if (id == `ID_LUI) begin
            w[31:12] = imm[31:12];
            w[11:7]  = rd;
            w[6:0]   = 7'h37;
        end else if (id == `ID_BNE) begin
            w[31]    = imm[12];
            w[30:25] = imm[10:5];
            w[24:20] = rs2;
            w[19:15] = rs1;
            w[14:12] = 3'd1;
            w[11:8]  = imm[4:1];
            w[7]     = imm[11];
            w[6:0]   = 7'h63;
        end else if (id == `ID_JAL) begin
            w[31]    = imm[20];
            w[30:21] = imm[10:1];
            w[20]    = imm[11];
            w[19:12] = imm[19:12];
            w[11:7]  = rd;
            w[6:0]   = 7'h6F;
        end else if (id == `ID_SW) begin
            w[31:25] = imm[11:5];
            w[24:20] = rs2;
            w[19:15] = rs1;
            w[14:12] = 3'd2;
            w[11:7]  = imm[4:0];
            w[6:0]   = 7'h23;
        end
        return w;
    endfunction

    // -------------------------------------------------------------------------
    // Monitor / scoreboard (negedge, away from the active edge)
    // -------------------------------------------------------------------------
    initial forever begin
        logic        ready_m;
        logic [31:0] w;
        @(negedge clk);
        if (!rst_n) begin
            exp_q.delete();
            exp_b_q.delete();
            m_addr   = ADDR_W'(BASE);
            m_addr_b = '0;
            m_error  = 1'b0;
        end else begin
            ready_m = !hold && (exp_q.size() < 2);
            check_eq("in_ready",    in_ready,    ready_m);
            check_eq("in_ready_b",  in_ready_b,  ready_m);
            check_eq("out_valid",   out_valid,   exp_q.size() != 0);
            check_eq("out_valid_b", out_valid_b, exp_b_q.size() != 0);
            check_eq("error",       error,       m_error);
            check_eq("error_b",     error_b,     m_error);
            if (exp_q.size() != 0) begin
                check_eq("out_inst", out_inst, exp_q[0][31:0]);
                check_eq("out_addr", out_addr, exp_q[0][ADDR_W+31:32]);
            end
            if (exp_b_q.size() != 0) begin
                check_eq("out_inst_b", out_inst_b, exp_b_q[0][31:0]);
                check_eq("out_addr_b", out_addr_b, exp_b_q[0][ADDR_WB+31:32]);
            end
            if (out_ready && exp_q.size() != 0) exp_q.delete(0);
            if (out_ready && exp_b_q.size() != 0) exp_b_q.delete(0);
            if (in_valid && ready_m) begin
                acc_cnt++;
                if (model_legal(in_instID, in_imm)) begin
                    w = drv_has_known ? drv_known : model_enc(in_instID, in_rd, in_rs1, in_rs2, in_imm);
                    exp_q.push_back({m_addr, w});
                    exp_b_q.push_back({m_addr_b, w});
                    m_addr   = m_addr + ADDR_W'(1);
                    m_addr_b = m_addr_b + ADDR_WB'(1);
                end else begin
                    m_error = 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Driver tasks
    // -------------------------------------------------------------------------
    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [`InstIDDepth-1:0] id, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                        input logic has_known, input logic [31:0] known);
        int start;
        int waited;
        in_instID     = id;
        in_rd         = rd;
        in_rs1        = rs1;
        in_rs2        = rs2;
        in_imm        = imm;
        drv_has_known = has_known;
        drv_known     = known;
        in_valid      = 1'b1;
        start  = acc_cnt;
        waited = 0;
        while (acc_cnt == start && waited < 40) begin
            @(posedge clk);
            #1;
            waited++;
            if (rand_mode) begin
                hold      = ($urandom_range(0, 3) == 0);
                out_ready = ($urandom_range(0, 1) == 1);
            end
        end
        check_eq("accept_in_time", acc_cnt != start, 1'b1);
        in_valid      = 1'b0;
        drv_has_known = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_in_ready",  in_ready,  1'b0);
        check_eq("rst_out_inst",  out_inst,  32'h0);
        check_eq("rst_out_addr",  out_addr,  '0);
        check_eq("rst_error",     error,     1'b0);
        check_eq("rst_out_valid_b", out_valid_b, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        int c0;
        int waited;
        logic [`InstIDDepth-1:0] unk_id;
        logic [`InstIDDepth-1:0] rid;
        logic [31:0] rimm;
        unk_id = '1;

        // Reset state
        #1;
        check_eq("init_out_valid", out_valid, 1'b0);
        check_eq("init_in_ready",  in_ready,  1'b0);
        check_eq("init_out_inst",  out_inst,  32'h0);
        check_eq("init_out_addr",  out_addr,  '0);
        check_eq("init_error",     error,     1'b0);
        #20;
        rst_n = 1'b1;
        cycles(1);

        // First word: one cycle after accept, address BASE
        out_ready = 1'b0;
        send(`ID_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h00500093);
        check_eq("first_valid", out_valid, 1'b1);
        check_eq("first_addr",  out_addr,  ADDR_W'(BASE));
        out_ready = 1'b1;
        cycles(2);

        // Back-to-back, no bubbles
        c0 = cyc;
        send(`ID_ADD, 5'd3, 5'd1, 5'd2, 32'd0,          1'b1, 32'h002081B3);
        send(`ID_LUI, 5'd5, 5'd0, 5'd0, 32'h12345000,   1'b1, 32'h123452B7);
        send(`ID_LW,  5'd3, 5'd1, 5'd0, 32'd4,          1'b1, 32'h0040A183);
        send(`ID_SW,  5'd0, 5'd1, 5'd2, 32'd8,          1'b1, 32'h0020A423);
        check_eq("b2b_cycles", cyc - c0, 4);
        send(`ID_BNE, 5'd0, 5'd1, 5'd2, 32'hFFFFFFF8,   1'b1, 32'hFE209CE3);
        send(`ID_JAL, 5'd1, 5'd0, 5'd0, 32'd16,         1'b1, 32'h010000EF);
        cycles(3);

        // Backpressure: third request waits until the consumer drains
        out_ready = 1'b0;
        send(`ID_ADDI, 5'd7, 5'd3, 5'd0, 32'hFFFFFFFF, 1'b0, 32'h0);
        send(`ID_ADD,  5'd8, 5'd4, 5'd5, 32'd0,        1'b0, 32'h0);
        fork
            send(`ID_SW, 5'd0, 5'd6, 5'd9, 32'hFFFFFFE0, 1'b0, 32'h0);
            begin
                cycles(4);
                check_eq("bp_in_ready", in_ready, 1'b0);
                check_eq("bp_count",    exp_q.size(), 2);
                out_ready = 1'b1;
            end
        join
        cycles(4);

        // Illegal ID, then a legal word takes the skipped address
        send(unk_id, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 32'h0);
        send(`ID_ADDI, 5'd2, 5'd2, 5'd0, 32'd1, 1'b0, 32'h0);
        // Range-limited immediate: flagged when checking, truncated otherwise
        send(`ID_ADDI, 5'd3, 5'd0, 5'd0, 32'd2048, 1'b0, 32'h0);
        cycles(3);
        check_eq("err_sticky", error, 1'b1);

        // Randomised traffic with random hold / out_ready
        rand_mode = 1'b1;
        for (int i = 0; i < 80; i++) begin
            rid  = `InstIDDepth'($urandom_range(0, 7));
            rimm = ($urandom_range(0, 1) == 1) ? $urandom : 32'($signed($urandom_range(0, 8191)) - 4096);
            send(rid, 5'($urandom), 5'($urandom), 5'($urandom), rimm, 1'b0, 32'h0);
        end
        rand_mode = 1'b0;
        hold      = 1'b0;
        out_ready = 1'b1;
        waited = 0;
        while (exp_q.size() != 0 && waited < 60) begin
            cycles(1);
            waited++;
        end
        check_eq("drain_empty", exp_q.size(), 0);

        // Reset with two words queued
        out_ready = 1'b0;
        send(`ID_ADDI, 5'd4, 5'd4, 5'd0, 32'd9,  1'b0, 32'h0);
        send(`ID_ADDI, 5'd5, 5'd5, 5'd0, 32'd10, 1'b0, 32'h0);
        do_reset();
        cycles(1);
        send(`ID_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h00500093);
        check_eq("post_rst_addr", out_addr, ADDR_W'(BASE));
        out_ready = 1'b1;
        cycles(1);

        // Narrow counter: five pushes wrap 0,1,2,3,0 (checked by the monitor)
        send(`ID_LUI,  5'd1, 5'd0, 5'd0, 32'hABCDE000, 1'b0, 32'h0);
        send(`ID_ADD,  5'd2, 5'd3, 5'd4, 32'd0,        1'b0, 32'h0);
        send(`ID_BNE,  5'd0, 5'd5, 5'd6, 32'd12,       1'b0, 32'h0);
        send(`ID_JAL,  5'd0, 5'd0, 5'd0, 32'hFFFFFFF0, 1'b0, 32'h0);
        check_eq("wrap_b_addr", out_addr_b, 2'd0);
        cycles(4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
